ascon_ct_stream_out: RTL
========================

Name: ascon_ct_stream_out

Overview:
- Downstream stage of the ASCON controller.
- Captures each ciphertext/plaintext block, which arrives as a one-cycle strobe: CTblock, CTv and datalen.
- Captures the final 128-bit Tag, which arrives as a one-cycle Tv strobe.
- Buffers blocks in a small FIFO and serialises them to a valid/ready byte-lane stream: data bytes first, then tag bytes.
- Decouples the fixed-cadence controller from a back-pressuring consumer (bus bridge or UART packer).

Parameters:
- DEPTH, 4, CT FIFO entries (power of 2, ≥2); each entry holds 64 data bits plus a 4-bit length.
- BEAT_BYTES, 2, bytes per output beat (1, 2, 4 or 8).

Ports:
- clk  in  1  clock.
- RST  in  1  asynchronous, active-high reset.
- CTblock  in  64  block from controller; byte 0 = bits 63:56.
- CTv  in  1  one-cycle strobe; CTblock is valid this cycle.
- datalen  in  4  valid byte count of CTblock, sampled with CTv.
- Tag  in  128  tag; byte 0 = bits 127:120.
- Tv  in  1  one-cycle strobe; Tag is valid this cycle.
- dout  out  8*BEAT_BYTES  output beat; lane 0 = MS byte.
- dout_keep  out  BEAT_BYTES  per-lane byte valid, MS-first contiguous.
- dout_valid  out  1  beat available.
- dout_ready  in  1  consumer accepts the beat.
- dout_tag  out  1  current beat is tag data.
- dout_last  out  1  final beat of the message (last tag beat).
- busy  out  1  FIFO non-empty, tag pending, or output active.
- overflow  out  1  sticky; a capture was dropped.

Behaviour:
- Reset (asynchronous, RST=1):
  - FIFO empty, tag pending=0, byte pointer=0, state=IDLE.
  - All outputs 0.
- Capture:
  - CTv=1 with FIFO not full: push {CTblock, len}, where len = datalen clamped to 8 if datalen>8.
  - CTv=1 with datalen=0: ignored, no push.
  - CTv=1 with FIFO full: block dropped, overflow<=1.
  - Tv=1 with no tag pending: latch Tag, tag_pending<=1.
  - Tv=1 with tag pending: drop, overflow<=1.
  - CTv and Tv in the same cycle: both captured; the tag is still emitted after that block.
  - A push in the same cycle as a pop from a full FIFO is accepted (pop frees the slot first).
- State machine: IDLE, CT_OUT, TAG_OUT.
  - IDLE -> CT_OUT when FIFO non-empty.
  - IDLE -> TAG_OUT when FIFO empty and tag pending.
  - CT_OUT: emits the head entry in beats of min(BEAT_BYTES, len-ptr) bytes.
    - dout_keep marks the valid lanes; unused lanes drive 0.
    - ptr advances by BEAT_BYTES per accepted beat.
    - When ptr ≥ len: pop, ptr<=0.
    - After the pop: stay in CT_OUT if FIFO non-empty; else go to TAG_OUT if tag pending; else IDLE.
  - TAG_OUT: emits 16/BEAT_BYTES full beats with dout_tag=1.
    - dout_last=1 on the final beat.
    - On its acceptance: tag_pending<=0, go to IDLE, or CT_OUT if FIFO non-empty.
- Handshake:
  - Beat transfers when dout_valid && dout_ready.
  - While valid && !ready: dout, keep, tag and last hold stable.
  - Valid never drops without a transfer, except on reset.
- Latency:
  - First beat is valid on the cycle after the CTv capture (registered FIFO).
  - One beat per cycle sustained under dout_ready=1.
- No padding bytes are ever emitted; a partial block emits exactly len bytes.
- overflow clears only on reset.
- Reset mid-beat: stream aborts; no recovery of buffered data.

Optional Feature:
- Macro: ASCON_TAG_CHECK_EN. When defined, adds these ports:
  - exp_tag  in  128
  - chk_en  in  1, sampled with Tv
  - tag_done  out  1
  - tag_ok  out  1
- With chk_en=1 at Tv:
  - No TAG_OUT beats are produced.
  - When the FIFO is drained, tag_done pulses for one cycle with tag_ok = (Tag==exp_tag).
  - dout_last is asserted on the final CT beat instead.
- With chk_en=0, or macro undefined: the tag is streamed as above.
- Macro undefined: tag_done/tag_ok ports do not exist.

Test Plan:
- BEAT_BYTES=2, ready=1: CTv with CTblock=0x0011223344556677, datalen=8 -> 4 beats 0x0011, 0x2233, 0x4455, 0x6677, keep=2'b11, dout_tag=0.
- Partial block, datalen=3, CTblock=0xAABBCC0000000000 -> beats 0xAABB keep=11, then 0xCC00 keep=10; no further CT beats.
- Full message: two 8-byte blocks plus Tv with Tag=0x000102…0F, ready=1 -> 8 CT beats, then 8 tag beats 0x0001…0x0E0F, with dout_last on 0x0E0F only.
- Back-pressure: ready=0 for 10 cycles during a beat -> dout/keep stable, valid held; 5 blocks pushed with DEPTH=4 -> 5th dropped, overflow=1 and stays 1.
- Simultaneous CTv (datalen=5) and Tv in one cycle -> 5 CT bytes emitted before any tag beat; RST asserted mid-tag -> valid=0, busy=0 immediately.
- ASCON_TAG_CHECK_EN, chk_en=1, exp_tag equal to Tag -> tag_done=1 for one cycle with tag_ok=1, after the last CT beat; with exp_tag differing in bit 0 -> tag_ok=0.

Source files
------------

// File: rtl/ascon_ct_stream_out_if.sv
// Valid/ready byte-lane stream carrying ASCON ciphertext and tag beats.
// Lane 0 is the most-significant byte of dout and the MSB of dout_keep.
interface ascon_ct_stream_out_if #(
  parameter int BEAT_BYTES = 2
);
  logic [8*BEAT_BYTES-1:0] dout;
  logic [BEAT_BYTES-1:0]   dout_keep;
  logic                    dout_valid;
  logic                    dout_ready;
  logic                    dout_tag;
  logic                    dout_last;

  modport master (
    output dout, dout_keep, dout_valid, dout_tag, dout_last,
    input  dout_ready
  );

  modport slave (
    input  dout, dout_keep, dout_valid, dout_tag, dout_last,
    output dout_ready
  );
endinterface

// File: rtl/ascon_ct_stream_out.sv
// Buffers ASCON controller blocks and the final tag, then serialises them onto a byte-lane stream.
// Optional macro ASCON_TAG_CHECK_EN replaces tag streaming with an on-chip compare against exp_tag.
module ascon_ct_stream_out #(
  parameter int DEPTH      = 4,
  parameter int BEAT_BYTES = 2
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic [63:0]            CTblock,
  input  logic                   CTv,
  input  logic [3:0]             datalen,
  input  logic [127:0]           Tag,
  input  logic                   Tv,
`ifdef ASCON_TAG_CHECK_EN
  input  logic [127:0]           exp_tag,
  input  logic                   chk_en,
  output logic                   tag_done,
  output logic                   tag_ok,
`endif
  ascon_ct_stream_out_if.master  out_if,
  output logic                   busy,
  output logic                   overflow
);

  localparam int              AW = $clog2(DEPTH);
  localparam int              W  = 8 * BEAT_BYTES;
  localparam logic [5:0]      BB = 6'(BEAT_BYTES);

  typedef enum logic [1:0] {IDLE, CT_OUT, TAG_OUT} state_t;

  state_t       state;
  logic [63:0]  mem_data [DEPTH];
  logic [3:0]   mem_len  [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr, count, count_next;
  logic [4:0]   ptr;
  logic [127:0] tag_q;
  logic         tag_pending;

  logic [63:0]  head_data, ct_shift;
  logic [127:0] tag_shift;
  logic [W-1:0] ct_beat, tag_beat;
  logic [3:0]   head_len, len_in;
  logic [5:0]   ptr_sum;
  logic         fire, ct_done, tag_end, pop, push, ct_req, full;
  logic         nonempty_next, tag_set, tag_avail_next;
  logic         chk_mode, chk_next, chk_retire;

  assign count     = wr_ptr - rd_ptr;
  assign full      = (count == (AW+1)'(DEPTH));
  assign head_data = mem_data[rd_ptr[AW-1:0]];
  assign head_len  = mem_len[rd_ptr[AW-1:0]];
  assign ptr_sum   = {1'b0, ptr} + BB;
  assign ct_done   = (ptr_sum >= {2'b00, head_len});
  assign tag_end   = (ptr_sum >= 6'd16);

  assign fire = (state != IDLE) && out_if.dout_ready;
  assign pop  = (state == CT_OUT) && fire && ct_done;

  // A pop in the same cycle frees the head slot, so a full FIFO can still accept the push.
  assign ct_req = CTv && (datalen != 4'd0);
  assign push   = ct_req && (!full || pop);
  assign len_in = (datalen > 4'd8) ? 4'd8 : datalen;

  assign count_next     = count + (AW+1)'(push) - (AW+1)'(pop);
  assign nonempty_next  = (count_next != '0);
  assign tag_set        = Tv && !tag_pending;
  assign tag_avail_next = tag_pending || tag_set;

`ifdef ASCON_TAG_CHECK_EN
  logic tag_match;

  assign chk_next   = tag_set ? chk_en : chk_mode;
  assign chk_retire = chk_next && tag_avail_next &&
                      (((state == IDLE) && !nonempty_next) || (pop && (count == (AW+1)'(1))));

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      chk_mode  <= 1'b0;
      tag_match <= 1'b0;
      tag_done  <= 1'b0;
      tag_ok    <= 1'b0;
    end else begin
      if (tag_set) begin
        chk_mode  <= chk_en;
        tag_match <= (Tag == exp_tag);
      end
      tag_done <= chk_retire;
      tag_ok   <= chk_retire && (tag_set ? (Tag == exp_tag) : tag_match);
    end
  end
`else
  assign chk_mode   = 1'b0;
  assign chk_next   = 1'b0;
  assign chk_retire = 1'b0;
`endif

  // NOTE: FIFO storage has no reset; an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr[AW-1:0]] <= CTblock;
      mem_len[wr_ptr[AW-1:0]]  <= len_in;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ptr         <= '0;
      tag_q       <= '0;
      tag_pending <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if ((ct_req && !push) || (Tv && tag_pending)) overflow <= 1'b1;
      if (tag_set) begin
        tag_q       <= Tag;
        tag_pending <= 1'b1;
      end
      if (chk_retire) tag_pending <= 1'b0;

      case (state)
        IDLE: begin
          if (nonempty_next)                   state <= CT_OUT;
          else if (tag_avail_next && !chk_next) state <= TAG_OUT;
        end
        CT_OUT: begin
          if (pop) begin
            ptr <= '0;
            if (nonempty_next)                    state <= CT_OUT;
            else if (tag_avail_next && !chk_next) state <= TAG_OUT;
            else                                  state <= IDLE;
          end else if (fire) begin
            ptr <= ptr_sum[4:0];
          end
        end
        TAG_OUT: begin
          if (fire && tag_end) begin
            ptr         <= '0;
            tag_pending <= 1'b0;
            state       <= nonempty_next ? CT_OUT : IDLE;
          end else if (fire) begin
            ptr <= ptr_sum[4:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ct_shift  = head_data << {ptr, 3'b000};
  assign tag_shift = tag_q << {ptr, 3'b000};
  assign ct_beat   = ct_shift[63 -: W];
  assign tag_beat  = tag_shift[127 -: W];

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    out_if.dout       = '0;
    out_if.dout_keep  = '0;
    out_if.dout_valid = 1'b0;
    out_if.dout_tag   = 1'b0;
    out_if.dout_last  = 1'b0;
    case (state)
      CT_OUT: begin
        out_if.dout_valid = 1'b1;
        for (int i = 0; i < BEAT_BYTES; i++) begin
          if (({1'b0, ptr} + 6'(i)) < {2'b00, head_len}) begin
            out_if.dout_keep[BEAT_BYTES-1-i]     = 1'b1;
            out_if.dout[8*(BEAT_BYTES-1-i) +: 8] = ct_beat[8*(BEAT_BYTES-1-i) +: 8];
          end
        end
        // With the tag checked on-chip, the final data beat closes the message.
        out_if.dout_last = chk_mode && tag_pending && ct_done && (count == (AW+1)'(1));
      end
      TAG_OUT: begin
        out_if.dout_valid = 1'b1;
        out_if.dout_keep  = '1;
        out_if.dout       = tag_beat;
        out_if.dout_tag   = 1'b1;
        out_if.dout_last  = tag_end;
      end
      default: ;
    endcase
  end

  assign busy = (count != '0) || tag_pending || (state != IDLE);

endmodule
